move_issuer: RTL and testbench

- Producer side of the mark/position move interface consumed by the board recorder.
- Turns keypad presses into validated moves and enforces O/X alternation.
- Rejects illegal cells, forfeits a turn on inactivity timeout, and tracks each player's last HIST_DEPTH moves.
- Uses the move history to expose the cell that will vanish on the current player's next move, for display blinking.
- Sits between the keypad/debounce logic and the recorder; reads back the recorder's registered board.

---
 rtl/move_issuer.sv | 176 +++++++++++++++++
 tb/tb_move_issuer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_issuer.sv
// Keypad-to-move producer for the board recorder: validates presses, alternates O/X,
// forfeits idle turns and keeps per-player move histories for the vanishing-mark display.
module move_issuer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HIST_DEPTH     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_state,
    input  logic        key_valid,
    input  logic [3:0]  key_pos,
    input  logic [17:0] board,
    output logic [1:0]  mark,
    output logic [3:0]  position,
    output logic [1:0]  turn,
    output logic        oldest_valid,
    output logic [3:0]  oldest_pos,
    output logic        reject,
    output logic        timeout
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int FILL_W = $clog2(HIST_DEPTH + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(HIST_DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_COMMIT
    } state_t;

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [1:0]                            mark_q, mark_d;
    logic [3:0]                            position_q, position_d;
    logic [1:0]                            turn_q, turn_d;
    logic                                  reject_q, reject_d;
    logic                                  timeout_q, timeout_d;

    // Index 0 holds O's history, index 1 holds X's.
    logic [1:0][HIST_DEPTH-1:0][3:0]       hist_q, hist_d;
    logic [1:0][PTR_W-1:0]                 head_q, head_d;
    logic [1:0][PTR_W-1:0]                 tail_q, tail_d;
    logic [1:0][FILL_W-1:0]                fill_q, fill_d;

    logic                                  mover;
    logic                                  cell_free;
    logic                                  key_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // turn = 01 selects O (index 0), 10 selects X (index 1).
    assign mover = turn_q[1];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        cell_free = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (key_pos == 4'(i)) cell_free = (board[2*i +: 2] == 2'b00);
        end
    end

    assign key_ok = key_valid && cell_free;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mark_d     = 2'b00;
        position_d = position_q;
        turn_d     = turn_q;
        reject_d   = 1'b0;
        timeout_d  = 1'b0;
        hist_d     = hist_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;

        if (!game_state) begin
            state_d = S_IDLE;
            turn_d  = 2'b00;
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_KEY;
                    turn_d  = 2'b01;
                    cnt_d   = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    fill_d  = '0;
                end
                S_WAIT_KEY: begin
                    if (key_ok) begin
                        mark_d     = turn_q;
                        position_d = key_pos;
                        state_d    = S_COMMIT;
                    end else begin
                        // A rejected key neither restarts the idle count nor masks an expiry.
                        reject_d = key_valid;
                        if (cnt_q == CNT_MAX) begin
                            timeout_d = 1'b1;
                            turn_d    = {turn_q[0], turn_q[1]};
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    hist_d[mover][tail_q[mover]] = position_q;
                    tail_d[mover] = ptr_inc(tail_q[mover]);
                    if (fill_q[mover] == FILL_MAX) begin
                        head_d[mover] = ptr_inc(head_q[mover]);
                    end else begin
                        fill_d[mover] = fill_q[mover] + FILL_W'(1);
                    end
                    turn_d  = {turn_q[0], turn_q[1]};
                    cnt_d   = '0;
                    state_d = S_WAIT_KEY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mark_q     <= 2'b00;
            position_q <= 4'd0;
            turn_q     <= 2'b00;
            reject_q   <= 1'b0;
            timeout_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mark_q     <= mark_d;
            position_q <= position_d;
            turn_q     <= turn_d;
            reject_q   <= reject_d;
            timeout_q  <= timeout_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
        end
    end

    // NOTE: history storage is not reset; the fill counts are, and oldest_pos is gated by them.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign oldest_valid = (turn_q != 2'b00) && (fill_q[mover] == FILL_MAX);
    assign oldest_pos   = oldest_valid ? hist_q[mover][head_q[mover]] : 4'd0;

    assign mark     = mark_q;
    assign position = position_q;
    assign turn     = turn_q;
    assign reject   = reject_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_move_issuer.sv
// Bench for move_issuer: directed scenarios plus random key traffic, checked against a
// queue-based model of turns, idle time and per-player move histories.
module tb_move_issuer;

    localparam int TO = 8;
    localparam int HD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_state;
    logic        key_valid;
    logic [3:0]  key_pos;
    logic [17:0] board;
    logic [1:0]  mark;
    logic [3:0]  position;
    logic [1:0]  turn;
    logic        oldest_valid;
    logic [3:0]  oldest_pos;
    logic        reject;
    logic        timeout;

    move_issuer #(.TIMEOUT_CYCLES(TO), .HIST_DEPTH(HD)) dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .key_valid    (key_valid),
        .key_pos      (key_pos),
        .board        (board),
        .mark         (mark),
        .position     (position),
        .turn         (turn),
        .oldest_valid (oldest_valid),
        .oldest_pos   (oldest_pos),
        .reject       (reject),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: game phase, cycles waited in the current turn, move lists per player.
    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_COMMIT = 2;
    int         m_phase;
    int         m_waited;
    int         hist_o[$];
    int         hist_x[$];
    logic [1:0] e_mark;
    logic [1:0] e_turn;
    logic [3:0] e_pos;
    logic       e_rej;
    logic       e_to;

    bit         r_gs;
    bit         r_kv;
    logic [3:0] r_kp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] other(input logic [1:0] t);
        return (t == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        foreach (hist_o[i]) b[2*hist_o[i] +: 2] = 2'b01;
        foreach (hist_x[i]) b[2*hist_x[i] +: 2] = 2'b10;
        return b;
    endfunction

    function automatic bit cell_taken(input int kp);
        foreach (hist_o[i]) if (hist_o[i] == kp) return 1'b1;
        foreach (hist_x[i]) if (hist_x[i] == kp) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_waited = 0;
        hist_o.delete();
        hist_x.delete();
        e_mark = 2'b00;
        e_turn = 2'b00;
        e_pos  = 4'd0;
        e_rej  = 1'b0;
        e_to   = 1'b0;
    endtask

    // Advances the model by one clock given the inputs presented during that cycle.
    task automatic model_step(input bit gs, input bit kv, input int kp);
        e_mark = 2'b00;
        e_rej  = 1'b0;
        e_to   = 1'b0;
        if (!gs) begin
            m_phase  = P_IDLE;
            m_waited = 0;
            e_turn   = 2'b00;
            hist_o.delete();
            hist_x.delete();
        end else if (m_phase == P_IDLE) begin
            m_phase  = P_WAIT;
            m_waited = 0;
            e_turn   = 2'b01;
            hist_o.delete();
            hist_x.delete();
        end else if (m_phase == P_WAIT) begin
            if (kv && kp <= 8 && !cell_taken(kp)) begin
                e_mark  = e_turn;
                e_pos   = 4'(kp);
                m_phase = P_COMMIT;
            end else begin
                e_rej = kv;
                m_waited++;
                if (m_waited == TO) begin
                    e_to     = 1'b1;
                    e_turn   = other(e_turn);
                    m_waited = 0;
                end
            end
        end else begin
            if (e_turn == 2'b01) begin
                hist_o.push_back(int'(e_pos));
                if (hist_o.size() > HD) void'(hist_o.pop_front());
            end else begin
                hist_x.push_back(int'(e_pos));
                if (hist_x.size() > HD) void'(hist_x.pop_front());
            end
            e_turn   = other(e_turn);
            m_waited = 0;
            m_phase  = P_WAIT;
        end
    endtask

    task automatic check_all();
        bit exp_ov;
        int exp_op;
        exp_ov = 1'b0;
        exp_op = 0;
        if (e_turn == 2'b01 && hist_o.size() == HD) begin
            exp_ov = 1'b1;
            exp_op = hist_o[0];
        end
        if (e_turn == 2'b10 && hist_x.size() == HD) begin
            exp_ov = 1'b1;
            exp_op = hist_x[0];
        end
        check("mark", mark, e_mark);
        check("position", position, e_pos);
        check("turn", turn, e_turn);
        check("reject", reject, e_rej);
        check("timeout", timeout, e_to);
        check("oldest_valid", oldest_valid, exp_ov);
        if (exp_ov) check("oldest_pos", oldest_pos, exp_op);
    endtask

    task automatic cycle(input bit gs, input bit kv, input logic [3:0] kp);
        game_state = gs;
        key_valid  = kv;
        key_pos    = kp;
        model_step(gs, kv, int'(kp));
        @(posedge clk);
        #1;
        board     = model_board();
        key_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0);
    endtask

    // Key press followed by its commit cycle.
    task automatic do_move(input logic [3:0] kp);
        cycle(1'b1, 1'b1, kp);
        cycle(1'b1, 1'b0, 4'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mark"}, mark, 2'b00);
        check({tag, "_position"}, position, 4'd0);
        check({tag, "_turn"}, turn, 2'b00);
        check({tag, "_reject"}, reject, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_oldest_valid"}, oldest_valid, 1'b0);
        check({tag, "_oldest_pos"}, oldest_pos, 4'd0);
    endtask

    initial begin
        rst        = 1'b0;
        game_state = 1'b0;
        key_valid  = 1'b0;
        key_pos    = 4'd0;
        board      = '0;
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First move: O presses 4; key during COMMIT is ignored without reject.
        cycle(1'b1, 1'b0, 4'd0);
        check("start_turn", turn, 2'b01);
        idle(3);
        cycle(1'b1, 1'b1, 4'd4);
        check("m1_mark", mark, 2'b01);
        check("m1_pos", position, 4'd4);
        cycle(1'b1, 1'b1, 4'd0);
        check("m1_commit_mark", mark, 2'b00);
        check("m1_commit_reject", reject, 1'b0);
        check("m1_turn", turn, 2'b10);

        // Occupied cell and out-of-range cell.
        cycle(1'b1, 1'b1, 4'd4);
        check("occ_reject", reject, 1'b1);
        check("occ_mark", mark, 2'b00);
        check("occ_turn", turn, 2'b10);
        cycle(1'b1, 1'b1, 4'd12);
        check("range_reject", reject, 1'b1);
        idle(1);
        check("reject_clear", reject, 1'b0);

        // Restart, then alternate moves until histories wrap.
        cycle(1'b0, 1'b0, 4'd0);
        check("drop_turn", turn, 2'b00);
        cycle(1'b1, 1'b0, 4'd0);
        check("restart_turn", turn, 2'b01);
        do_move(4'd0);
        do_move(4'd1);
        do_move(4'd2);
        do_move(4'd3);
        do_move(4'd5);
        check("x_two_marks_ov", oldest_valid, 1'b0);
        do_move(4'd7);
        check("o_full_ov", oldest_valid, 1'b1);
        check("o_full_op", oldest_pos, 4'd0);
        do_move(4'd6);
        check("x_full_op", oldest_pos, 4'd1);
        do_move(4'd8);
        check("o_wrap_op", oldest_pos, 4'd2);

        // Forfeit after TO idle cycles, then an accepted key on the expiry cycle.
        idle(TO - 1);
        check("pre_to", timeout, 1'b0);
        idle(1);
        check("to_pulse", timeout, 1'b1);
        check("to_turn", turn, 2'b10);
        check("to_mark", mark, 2'b00);
        idle(TO - 1);
        cycle(1'b1, 1'b1, 4'd0);
        check("expiry_key_mark", mark, 2'b10);
        check("expiry_key_to", timeout, 1'b0);

        // game_state drops during COMMIT.
        cycle(1'b0, 1'b0, 4'd0);
        check("commit_drop_mark", mark, 2'b00);
        check("commit_drop_turn", turn, 2'b00);
        check("commit_drop_ov", oldest_valid, 1'b0);
        cycle(1'b1, 1'b0, 4'd0);
        check("rejoin_turn", turn, 2'b01);
        check("rejoin_ov", oldest_valid, 1'b0);

        // Asynchronous reset between edges, mid-game.
        do_move(4'd3);
        cycle(1'b1, 1'b1, 4'd5);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        board      = model_board();
        game_state = 1'b0;
        #2;
        rst = 1'b1;

        // Random traffic: sparse keys first (more timeouts), denser later.
        for (int i = 0; i < 1500; i++) begin
            r_gs = ($urandom_range(99) != 0);
            r_kv = ($urandom_range(7) < ((i < 750) ? 1 : 3));
            r_kp = ($urandom_range(9) < 7) ? 4'($urandom_range(8)) : 4'($urandom_range(15));
            cycle(r_gs, r_kv, r_kp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
